matmul_sequencer: RTL and testbench
===================================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter AWIDTH, default 7, RAM address width.
REQ-002 SHALL have parameter BUS_W, default 64, RAM word width (4 x 16-bit elements).
REQ-003 SHALL have parameter A_WORDS / B_WORDS / C_WORDS, default 8 each, words loaded to A, loaded to B, read from C per job.
REQ-004 SHALL have parameter WR_SKEW, default 2, cycles by which the address/enable path leads the data/we path inside the datapath.
REQ-005 SHALL have parameter RD_LAT, default 5, cycles from addr_pi issue to valid data_from_out_mat.
REQ-006 SHALL have parameter TIMEOUT, default 1023, maximum COMPUTE cycles.
REQ-007 Ports, with clock and reset first:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid / cmd_ready  in/out  1  job start handshake.
- in_valid / in_ready / in_data  in/out/in  1/1/BUS_W  operand stream, A words then B words.
- out_valid / out_ready / out_data  out/in/out  1/1/BUS_W  result stream.
- busy  out  1  high whenever state is not IDLE.
- error  out  1  sticky timeout flag.
- reset_0  out  1  active-high datapath clear.
- start_mat_mul_0  out  1  datapath start.
- done_mat_mul  in  1  datapath completion.
- enable_writing_to_mem / enable_reading_from_mem  out  1  datapath address-mux selects.
- addr_pi  out  AWIDTH  RAM address.
- data_pi  out  BUS_W  RAM write data.
- we_a / we_b / we_c  out  1  RAM write enables.
- data_from_out_mat  in  BUS_W  C read data.

Function
REQ-008 FSM states SHALL be IDLE, CLEAR, LOAD_A, LOAD_B, FLUSH, COMPUTE, DRAIN, ERR.
REQ-009 IDLE SHALL assert cmd_ready, and cmd_valid&cmd_ready SHALL move the FSM to CLEAR.
REQ-010 CLEAR SHALL assert reset_0 for exactly 2 cycles, clear the address counter, then go to LOAD_A.
REQ-011 LOAD_A/LOAD_B SHALL hold enable_writing_to_mem=1 and in_ready=1; each in_valid&in_ready beat SHALL drive addr_pi=counter and increment the counter.
REQ-012 data_pi and we_a (LOAD_A) or we_b (LOAD_B) for a beat SHALL appear exactly WR_SKEW cycles after that beat's addr_pi, via an internal delay line; we_* SHALL be 0 on cycles with no accepted beat.
REQ-013 After A_WORDS beats the counter SHALL reset to 0 and the FSM SHALL go to LOAD_B; after B_WORDS beats it SHALL go to FLUSH.
REQ-014 in_valid low SHALL stall loading with no write and no counter change.
REQ-015 FLUSH SHALL last WR_SKEW+1 cycles so the last write lands, then enable_writing_to_mem SHALL fall and the FSM SHALL go to COMPUTE.
REQ-016 COMPUTE SHALL hold start_mat_mul_0=1 and we_c=1 until done_mat_mul is sampled 1, then deassert both in the next cycle and go to DRAIN.
REQ-017 COMPUTE SHALL run a cycle counter; reaching TIMEOUT without done_mat_mul SHALL go to ERR.
REQ-018 DRAIN SHALL hold enable_reading_from_mem=1 and issue read addresses 0..C_WORDS-1.
REQ-019 An internal result FIFO (depth >= RD_LAT+1) SHALL capture data_from_out_mat exactly RD_LAT cycles after each issued read (issue-valid shift register).
REQ-020 A read SHALL be issued only when FIFO occupancy plus in-flight reads is below depth, so out_ready backpressure never drops data.
REQ-021 out_valid SHALL equal FIFO non-empty, and out_data SHALL equal the FIFO head.
REQ-022 After C_WORDS words leave on out_valid&out_ready, the FSM SHALL return to IDLE.
REQ-023 ERR SHALL set error=1, drive all datapath strobes to 0, and return to IDLE.
REQ-024 error SHALL be cleared only by reset_n or the next accepted cmd.
REQ-025 cmd_valid outside IDLE SHALL be ignored (cmd_ready=0).

Reset
REQ-026 reset_n low SHALL asynchronously force IDLE, all counters, the FIFO and the delay lines to empty.
REQ-027 While reset_n is low, reset_0 SHALL be 1 and every other output SHALL be 0 (including busy, error, cmd_ready).
REQ-028 Reset asserted mid-job SHALL abandon the job with no further RAM writes.
REQ-029 After reset_n releases, cmd_ready SHALL be 1 on the first cycle.

Verification
REQ-030 Nominal job: cmd, 8 A words 0x1..0x8 and 8 B words back-to-back -> we_a high 8 cycles with data_pi=0x1..0x8 two cycles after addr 0..7; start_mat_mul_0 high until done; 8 out words in address order; return to IDLE.
REQ-031 in_valid toggling every other cycle in LOAD_A -> exactly 8 we_a pulses, addresses 0..7 without gaps or repeats.
REQ-032 out_ready=0 for 20 cycles during DRAIN -> no more than FIFO-depth reads issued; all 8 words later delivered, none lost or duplicated.
REQ-033 done_mat_mul never asserted -> ERR after 1023 COMPUTE cycles; error=1, start_mat_mul_0=0, next cmd clears error.
REQ-034 reset_n pulsed low during LOAD_B word 3 -> immediate IDLE, no further we_b, reset_0=1 during reset, cmd_ready=1 after release.
REQ-035 cmd_valid held high throughout a job -> a second job starts only from IDLE, with a fresh 2-cycle reset_0 pulse.

Source files
------------

// File: rtl/matmul_sequencer_if.sv
// Command, operand and result streams plus status
// for the matmul job sequencer.
interface matmul_sequencer_if #(
  parameter int BUS_W = 64
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BUS_W-1:0] out_data;
  logic             busy;
  logic             error;

  modport master (
    output cmd_valid, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data,
    input  busy, error
  );

  modport slave (
    input  cmd_valid, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data,
    output busy, error
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Streams A/B operands into the matmul RAMs, runs the
// datapath, then drains C through a latency-matched FIFO.
module matmul_sequencer #(
  parameter int AWIDTH  = 7,
  parameter int BUS_W   = 64,
  parameter int A_WORDS = 8,
  parameter int B_WORDS = 8,
  parameter int C_WORDS = 8,
  parameter int WR_SKEW = 2,
  parameter int RD_LAT  = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  matmul_sequencer_if.slave bus,
  output logic              reset_0,
  output logic              start_mat_mul_0,
  input  logic              done_mat_mul,
  output logic              enable_writing_to_mem,
  output logic              enable_reading_from_mem,
  output logic [AWIDTH-1:0] addr_pi,
  output logic [BUS_W-1:0]  data_pi,
  output logic              we_a,
  output logic              we_b,
  output logic              we_c,
  input  logic [BUS_W-1:0]  data_from_out_mat
);
  localparam int DEPTH = RD_LAT + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int FW    = $clog2(DEPTH + 1);
  localparam int CW    = 16;

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD_A, LOAD_B,
    FLUSH, COMPUTE, DRAIN, ERR
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic error_q, error_d;

  logic [WR_SKEW-1:0] wa_q, wa_d, wb_q, wb_d;
  logic [BUS_W-1:0] wd_q [WR_SKEW];
  logic [BUS_W-1:0] wd_d [WR_SKEW];

  logic [RD_LAT-1:0] sr_q, sr_d;
  logic [FW-1:0] infl_q, infl_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [BUS_W-1:0] mem_q [DEPTH];

  logic cmd_rdy, clr, ld, wr_en, rd_en, start;
  logic beat_a, beat_b, issue, push, pop, room;
  logic [CW-1:0] addr;

  assign push = sr_q[RD_LAT-1];
  assign pop  = (fcnt_q != '0) && bus.out_ready;
  assign room = ({1'b0, fcnt_q} + {1'b0, infl_q})
              < (FW+1)'(DEPTH);

  // Job sequencing: next state, counters and strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    error_d   = error_q;
    cmd_rdy   = 1'b0;
    clr       = 1'b0;
    ld        = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    start     = 1'b0;
    beat_a    = 1'b0;
    beat_b    = 1'b0;
    issue     = 1'b0;
    addr      = '0;
    unique case (state_q)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (bus.cmd_valid) begin
          state_d = CLEAR;
          cnt_d   = '0;
          error_d = 1'b0;
        end
      end
      CLEAR: begin
        clr   = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        ld    = 1'b1;
        wr_en = 1'b1;
        addr  = cnt_q;
        if (bus.in_valid) begin
          beat_a = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(A_WORDS-1)) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end
        end
      end
      LOAD_B: begin
        ld    = 1'b1;
        wr_en = 1'b1;
        addr  = cnt_q;
        if (bus.in_valid) begin
          beat_b = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(B_WORDS-1)) begin
            cnt_d   = '0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        wr_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WR_SKEW)) begin
          cnt_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        start = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (done_mat_mul) begin
          cnt_d     = '0;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = DRAIN;
        end else if (cnt_q == CW'(TIMEOUT-1)) begin
          cnt_d   = '0;
          error_d = 1'b1;
          state_d = ERR;
        end
      end
      DRAIN: begin
        rd_en = 1'b1;
        addr  = rd_cnt_q;
        if (rd_cnt_q < CW'(C_WORDS) && room) begin
          issue    = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (pop) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_q == CW'(C_WORDS-1)) begin
            rd_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = IDLE;
          end
        end
      end
      ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write skew line, read-issue line and FIFO bookkeeping.
  always_comb begin
    wa_d = wa_q;
    wb_d = wb_q;
    wd_d = wd_q;
    sr_d = sr_q;
    for (int i = WR_SKEW-1; i > 0; i--) begin
      wa_d[i] = wa_q[i-1];
      wb_d[i] = wb_q[i-1];
      wd_d[i] = wd_q[i-1];
    end
    wa_d[0] = beat_a;
    wb_d[0] = beat_b;
    wd_d[0] = (beat_a | beat_b) ? bus.in_data : '0;
    for (int i = RD_LAT-1; i > 0; i--) begin
      sr_d[i] = sr_q[i-1];
    end
    sr_d[0] = issue;
    infl_d  = infl_q + FW'(issue) - FW'(push);
    fcnt_d  = fcnt_q + FW'(push) - FW'(pop);
    wp_d    = wp_q;
    rp_d    = rp_q;
    if (push) begin
      wp_d = (wp_q == PW'(DEPTH-1)) ? '0 : wp_q + 1'b1;
    end
    if (pop) begin
      rp_d = (rp_q == PW'(DEPTH-1)) ? '0 : rp_q + 1'b1;
    end
  end

  // State, counters and pipelines; reset empties everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_cnt_q  <= '0;
      out_cnt_q <= '0;
      error_q   <= 1'b0;
      wa_q      <= '0;
      wb_q      <= '0;
      for (int i = 0; i < WR_SKEW; i++) wd_q[i] <= '0;
      sr_q      <= '0;
      infl_q    <= '0;
      fcnt_q    <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      out_cnt_q <= out_cnt_d;
      error_q   <= error_d;
      wa_q      <= wa_d;
      wb_q      <= wb_d;
      wd_q      <= wd_d;
      sr_q      <= sr_d;
      infl_q    <= infl_d;
      fcnt_q    <= fcnt_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
    end
  end

  // Result FIFO storage; validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= data_from_out_mat;
  end

  assign bus.cmd_ready = cmd_rdy & reset_n;
  assign bus.in_ready  = ld;
  assign bus.out_valid = (fcnt_q != '0);
  assign bus.out_data  = mem_q[rp_q];
  assign bus.busy      = (state_q != IDLE);
  assign bus.error     = error_q;

  assign reset_0                 = clr | ~reset_n;
  assign start_mat_mul_0         = start;
  assign we_c                    = start;
  assign enable_writing_to_mem   = wr_en;
  assign enable_reading_from_mem = rd_en;
  assign addr_pi                 = AWIDTH'(addr);
  assign data_pi                 = wd_q[WR_SKEW-1];
  assign we_a                    = wa_q[WR_SKEW-1];
  assign we_b                    = wb_q[WR_SKEW-1];
endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with a RAM/datapath
// read model of fixed latency.
module tb_matmul_sequencer;
  localparam int BW = 64;
  localparam int RL = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic reset_0, start_mat_mul_0, done_mat_mul;
  logic en_w, en_r, we_a, we_b, we_c;
  logic [6:0] addr_pi;
  logic [BW-1:0] data_pi, data_from_out_mat;

  matmul_sequencer_if #(.BUS_W(BW)) bus ();

  matmul_sequencer dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .bus                     (bus),
    .reset_0                 (reset_0),
    .start_mat_mul_0         (start_mat_mul_0),
    .done_mat_mul            (done_mat_mul),
    .enable_writing_to_mem   (en_w),
    .enable_reading_from_mem (en_r),
    .addr_pi                 (addr_pi),
    .data_pi                 (data_pi),
    .we_a                    (we_a),
    .we_b                    (we_b),
    .we_c                    (we_c),
    .data_from_out_mat       (data_from_out_mat)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BW-1:0] cmem(input logic [6:0] a);
    return 64'hC0DE_0000_0000_0000 | (64'(a) * 64'h0001_0001);
  endfunction

  logic [6:0] rpipe [RL] = '{default: '0};
  always @(posedge clk) begin
    rpipe[0] <= addr_pi;
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign data_from_out_mat = cmem(rpipe[RL-1]);

  typedef struct {int c; logic [6:0] a; logic [BW-1:0] d;} beat_t;
  typedef struct {int c; logic [BW-1:0] d; logic isa;} wr_t;
  beat_t beats[$];
  wr_t wrs[$];
  logic [BW-1:0] outs[$];
  beat_t mb;
  wr_t mw;

  always @(negedge clk) begin
    if (bus.in_valid && bus.in_ready) begin
      mb.c = cyc; mb.a = addr_pi; mb.d = bus.in_data;
      beats.push_back(mb);
    end
    if (we_a || we_b) begin
      mw.c = cyc; mw.d = data_pi; mw.isa = we_a;
      wrs.push_back(mw);
    end
    if (bus.out_valid && bus.out_ready) outs.push_back(bus.out_data);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [BW-1:0] w [16];

  task automatic send_cmd(input bit hold);
    int n = 0;
    beats.delete(); wrs.delete(); outs.delete();
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready_wait", bus.cmd_ready, 1);
    tick();
    if (!hold) bus.cmd_valid = 1'b0;
    chk("clear_c0", reset_0, 1);
    chk("clear_busy", bus.busy, 1);
    chk("err_cleared", bus.error, 0);
    tick();
    chk("clear_c1", reset_0, 1);
    tick();
    chk("clear_end", reset_0, 0);
    chk("load_in_ready", bus.in_ready, 1);
    chk("load_wr_en", en_w, 1);
    if (hold) chk("cmd_ignored", bus.cmd_ready, 0);
  endtask

  task automatic load(input bit gap, input int nb, input int k);
    for (int i = 0; i < 16; i++)
      w[i] = (i < 8) ? 64'(i + 1) : 64'(k * 256 + i);
    for (int i = 0; i < 8 + nb; i++) begin
      if (gap && i < 8) begin bus.in_valid = 1'b0; tick(); end
      bus.in_valid = 1'b1;
      bus.in_data = w[i];
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic flush_and_check();
    chk("flush_wr_en", en_w, 1);
    chk("flush_no_start", start_mat_mul_0, 0);
    tick(); tick();
    chk("flush_last_wr_en", en_w, 1);
    tick();
    chk("compute_start", start_mat_mul_0, 1);
    chk("compute_we_c", we_c, 1);
    chk("compute_wr_off", en_w, 0);
    chk("n_beats", beats.size(), 16);
    chk("n_writes", wrs.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < beats.size() && i < wrs.size()) begin
        chk("beat_addr", beats[i].a, i % 8);
        chk("wr_data", wrs[i].d, w[i]);
        chk("wr_skew", wrs[i].c, beats[i].c + 2);
        chk("wr_sel_a", wrs[i].isa, (i < 8));
      end
    end
  endtask

  task automatic job(input bit gap, input bit stall,
                     input bit hold, input int k);
    int n = 0;
    send_cmd(hold);
    load(gap, 8, k);
    flush_and_check();
    repeat (4) tick();
    chk("start_held", start_mat_mul_0, 1);
    if (stall) bus.out_ready = 1'b0;
    done_mat_mul = 1'b1;
    tick();
    done_mat_mul = 1'b0;
    chk("start_drop", start_mat_mul_0, 0);
    chk("we_c_drop", we_c, 0);
    chk("drain_rd_en", en_r, 1);
    if (stall) begin
      repeat (20) tick();
      chk("stall_reads_issued", addr_pi, 6);
      chk("stall_no_out", outs.size(), 0);
      chk("stall_out_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    while (outs.size() < 8 && n < 200) begin tick(); n++; end
    chk("n_outs", outs.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < outs.size()) chk("out_data", outs[i], cmem(7'(i)));
    chk("done_idle_busy", bus.busy, 0);
    chk("done_idle_rdy", bus.cmd_ready, 1);
    if (hold) begin
      tick();
      chk("rehold_clear0", reset_0, 1);
      chk("rehold_busy", bus.busy, 1);
      tick();
      chk("rehold_clear1", reset_0, 1);
      tick();
      chk("rehold_clear_end", reset_0, 0);
      bus.cmd_valid = 1'b0;
    end else begin
      tick(); tick();
      chk("no_extra_outs", outs.size(), 8);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    done_mat_mul = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reset_0", reset_0, 1);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_we_a", we_a, 0);
    chk("rst_start", start_mat_mul_0, 0);
    reset_n = 1'b1;
    #1;
    chk("rel_cmd_ready", bus.cmd_ready, 1);
    chk("rel_reset_0", reset_0, 0);
    tick();

    job(1'b0, 1'b0, 1'b0, 1);
    job(1'b1, 1'b0, 1'b0, 2);
    job(1'b0, 1'b1, 1'b0, 3);

    send_cmd(1'b0);
    load(1'b0, 8, 4);
    flush_and_check();
    n = 0;
    while (start_mat_mul_0 && n < 1100) begin tick(); n++; end
    chk("timeout_cycles", n, 1023);
    chk("err_flag", bus.error, 1);
    chk("err_start", start_mat_mul_0, 0);
    chk("err_we_c", we_c, 0);
    chk("err_wr_en", en_w, 0);
    chk("err_busy", bus.busy, 1);
    tick();
    chk("err_idle_rdy", bus.cmd_ready, 1);
    chk("err_sticky", bus.error, 1);

    send_cmd(1'b0);
    load(1'b0, 3, 5);
    bus.in_valid = 1'b1;
    bus.in_data = 64'hDEAD;
    #2;
    reset_n = 1'b0;
    #1;
    wrs.delete();
    chk("mid_rst_reset_0", reset_0, 1);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_we_b", we_b, 0);
    chk("mid_rst_wr_en", en_w, 0);
    tick(); tick();
    chk("mid_rst_hold", reset_0, 1);
    reset_n = 1'b1;
    #1;
    chk("post_rst_rdy", bus.cmd_ready, 1);
    chk("post_rst_reset_0", reset_0, 0);
    repeat (6) tick();
    chk("post_rst_no_writes", wrs.size(), 0);
    chk("post_rst_idle", bus.busy, 0);
    bus.in_valid = 1'b0;

    job(1'b0, 1'b0, 1'b1, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
